// File: rtl/life_cell_gen.sv
// Life-like cellular-automaton cell with loadable birth/survive masks and Generations-style decay.
// Optional age counter enabled by defining LIFE_CELL_AGE_EN.
module life_cell_gen #(
   parameter int             NEIGHBORS       = 8,
   parameter int             STATES          = 2,
   parameter logic [8:0]     BIRTH_DEFAULT   = 9'b000001000,
   parameter logic [8:0]     SURVIVE_DEFAULT = 9'b000001100,
   parameter int             AGE_W           = 8,
   localparam int            SW              = $clog2(STATES),
   localparam int            CW              = $clog2(NEIGHBORS + 1)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 ena,
   input  logic                 state_0,
   input  logic [NEIGHBORS-1:0] neighbors,
   input  logic                 rule_load,
   input  logic [NEIGHBORS:0]   birth_in,
   input  logic [NEIGHBORS:0]   survive_in,
   output logic [SW-1:0]        state_d,
   output logic [SW-1:0]        state_q,
   output logic                 alive,
   output logic                 changed,
   output logic [AGE_W-1:0]     age
);

   // State a surviving-check failure falls to: dead for plain Life, first dying state otherwise.
   localparam logic [SW-1:0] DECAY = SW'((STATES == 2) ? 0 : 2);

   logic [SW-1:0]      r_state;
   logic               r_changed;
   logic [NEIGHBORS:0] r_birth;
   logic [NEIGHBORS:0] r_survive;
   logic [CW-1:0]      w_count;
   logic [SW-1:0]      w_state_d;

   // Live-neighbour count.
   always_comb begin
      w_count = '0;
      for (int i = 0; i < NEIGHBORS; i++) begin
         w_count = w_count + CW'(neighbors[i]);
      end
   end

   // Next-state rule; unreachable encodings at or above STATES collapse to dead.
   always_comb begin
      w_state_d = '0;
      if (r_state == '0) begin
         w_state_d = SW'(r_birth[w_count]);
      end else if (r_state == SW'(1)) begin
         w_state_d = r_survive[w_count] ? SW'(1) : DECAY;
      end else if (32'(r_state) < 32'(STATES - 1)) begin
         w_state_d = r_state + SW'(1);
      end else begin
         w_state_d = '0;
      end
   end

   // Cell state and change pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= SW'(state_0);
         r_changed <= 1'b0;
      end else if (ena) begin
         r_state   <= w_state_d;
         r_changed <= (w_state_d != r_state);
      end else begin
         r_state   <= r_state;
         r_changed <= 1'b0;
      end
   end

   // Rule masks; a same-cycle load only takes effect after this edge's update.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_birth   <= BIRTH_DEFAULT[NEIGHBORS:0];
         r_survive <= SURVIVE_DEFAULT[NEIGHBORS:0];
      end else if (rule_load) begin
         r_birth   <= birth_in;
         r_survive <= survive_in;
      end else begin
         r_birth   <= r_birth;
         r_survive <= r_survive;
      end
   end

`ifdef LIFE_CELL_AGE_EN
   logic [AGE_W-1:0] r_age;

   // Saturating count of consecutive alive generations.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_age <= '0;
      end else if (ena) begin
         if (r_state == SW'(1) && w_state_d == SW'(1)) begin
            if (r_age != '1) begin
               r_age <= r_age + AGE_W'(1);
            end else begin
               r_age <= r_age;
            end
         end else begin
            r_age <= '0;
         end
      end else begin
         r_age <= r_age;
      end
   end

   assign age = r_age;
`else
   assign age = '0;
`endif

   assign state_d = w_state_d;
   assign state_q = r_state;
   assign alive   = (r_state == SW'(1));
   assign changed = r_changed;

endmodule

// File: tb/tb_life_cell_gen.sv
// Bench for life_cell_gen: plain Life cell (A) and a 4-state Generations cell with 2-bit age (B),
// both driven by shared inputs and checked every cycle against a rule-level model.
module tb_life_cell_gen;

`ifdef LIFE_CELL_AGE_EN
   localparam bit AGE_ON = 1'b1;
`else
   localparam bit AGE_ON = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst, ena, state_0, rule_load;
   logic [7:0] neighbors;
   logic [8:0] birth_in, survive_in;

   logic [0:0] a_state_d, a_state_q;
   logic       a_alive, a_changed;
   logic [7:0] a_age;
   logic [1:0] b_state_d, b_state_q;
   logic       b_alive, b_changed;
   logic [1:0] b_age;

   int total = 0;
   int bad   = 0;

   // Model state
   bit         m_valid = 1'b0;
   int         ma_s, mb_s, ma_age, mb_age;
   bit         ma_c, mb_c;
   logic [8:0] m_birth, m_surv;

   always #5 clk = ~clk;

   life_cell_gen #(.NEIGHBORS(8), .STATES(2), .AGE_W(8)) u_a (
      .clk(clk), .rst(rst), .ena(ena), .state_0(state_0), .neighbors(neighbors),
      .rule_load(rule_load), .birth_in(birth_in), .survive_in(survive_in),
      .state_d(a_state_d), .state_q(a_state_q), .alive(a_alive), .changed(a_changed), .age(a_age));

   life_cell_gen #(.NEIGHBORS(8), .STATES(4), .AGE_W(2)) u_b (
      .clk(clk), .rst(rst), .ena(ena), .state_0(state_0), .neighbors(neighbors),
      .rule_load(rule_load), .birth_in(birth_in), .survive_in(survive_in),
      .state_d(b_state_d), .state_q(b_state_q), .alive(b_alive), .changed(b_changed), .age(b_age));

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int nxt(input int s, input logic [7:0] nb, input logic [8:0] b,
                              input logic [8:0] sv, input int states);
      int n;
      n = $countones(nb);
      if (s == 0) return b[n] ? 1 : 0;
      if (s == 1) return sv[n] ? 1 : ((states == 2) ? 0 : 2);
      if (s < states - 1) return s + 1;
      return 0;
   endfunction

   function automatic int age_next(input int s, input int ns, input int a, input int max);
      if (!AGE_ON) return 0;
      if (s == 1 && ns == 1) return (a < max) ? a + 1 : max;
      return 0;
   endfunction

   function automatic int ae(input int v);
      return AGE_ON ? v : 0;
   endfunction

   // Model update on each rising edge from the inputs held across it.
   always @(posedge clk) begin
      int na, nb2;
      if (rst) begin
         m_valid = 1'b1;
         ma_s = int'(state_0); mb_s = int'(state_0);
         ma_c = 1'b0; mb_c = 1'b0; ma_age = 0; mb_age = 0;
         m_birth = 9'b000001000; m_surv = 9'b000001100;
      end else if (m_valid) begin
         if (ena) begin
            na  = nxt(ma_s, neighbors, m_birth, m_surv, 2);
            nb2 = nxt(mb_s, neighbors, m_birth, m_surv, 4);
            ma_c = (na != ma_s); mb_c = (nb2 != mb_s);
            ma_age = age_next(ma_s, na, ma_age, 255);
            mb_age = age_next(mb_s, nb2, mb_age, 3);
            ma_s = na; mb_s = nb2;
         end else begin
            ma_c = 1'b0; mb_c = 1'b0;
         end
         if (rule_load) begin
            m_birth = birth_in; m_surv = survive_in;
         end
      end
   end

   // Every-cycle comparison against the model.
   always @(negedge clk) begin
      if (m_valid) begin
         chk("a_state_d", int'(a_state_d), nxt(ma_s, neighbors, m_birth, m_surv, 2));
         chk("a_state_q", int'(a_state_q), ma_s);
         chk("a_alive",   int'(a_alive),   (ma_s == 1) ? 1 : 0);
         chk("a_changed", int'(a_changed), int'(ma_c));
         chk("a_age",     int'(a_age),     ma_age);
         chk("b_state_d", int'(b_state_d), nxt(mb_s, neighbors, m_birth, m_surv, 4));
         chk("b_state_q", int'(b_state_q), mb_s);
         chk("b_alive",   int'(b_alive),   (mb_s == 1) ? 1 : 0);
         chk("b_changed", int'(b_changed), int'(mb_c));
         chk("b_age",     int'(b_age),     mb_age);
      end
   end

   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   initial begin
      rst = 1'b1; ena = 1'b0; state_0 = 1'b0; rule_load = 1'b0;
      neighbors = 8'h00; birth_in = 9'h000; survive_in = 9'h000;
      cyc(); cyc();
      chk("rst_a_q", int'(a_state_q), 0);
      chk("rst_b_q", int'(b_state_q), 0);
      chk("rst_b_changed", int'(b_changed), 0);
      chk("rst_b_age", int'(b_age), 0);

      // Birth with B3
      rst = 1'b0; neighbors = 8'b0000_0111; ena = 1'b1;
      #1;
      chk("t1_a_d", int'(a_state_d), 1);
      cyc();
      chk("t1_a_q", int'(a_state_q), 1);
      chk("t1_a_changed", int'(a_changed), 1);
      chk("t1_a_age", int'(a_age), 0);

      // Survive with 2, then overcrowding
      neighbors = 8'b0000_0011; cyc();
      chk("t2_a_q_surv", int'(a_state_q), 1);
      chk("t2_a_changed_surv", int'(a_changed), 0);
      chk("t2_a_age_surv", int'(a_age), ae(1));
      neighbors = 8'b0000_1111; cyc();
      chk("t2_a_q_die", int'(a_state_q), 0);
      chk("t2_a_changed_die", int'(a_changed), 1);
      chk("t2_b_q_decay", int'(b_state_q), 2);
      chk("t2_b_age_die", int'(b_age), 0);
      ena = 1'b0; neighbors = 8'h00; cyc();
      chk("t2_b_hold", int'(b_state_q), 2);
      chk("t2_b_hold_changed", int'(b_changed), 0);
      ena = 1'b1; cyc();
      chk("t2_b_q3", int'(b_state_q), 3);
      cyc();
      chk("t2_b_q0", int'(b_state_q), 0);

      // Same-cycle rule load uses the old rules
      rule_load = 1'b1; birth_in = 9'b000000100; survive_in = 9'b000001100;
      neighbors = 8'b1000_0001; cyc();
      chk("t3_a_old_rule", int'(a_state_q), 0);
      rule_load = 1'b0; cyc();
      chk("t3_a_new_rule", int'(a_state_q), 1);
      chk("t3_b_new_rule", int'(b_state_q), 1);

      // Generations decay with survive=0
      ena = 1'b0; rule_load = 1'b1; birth_in = 9'b000001000; survive_in = 9'b000000000;
      neighbors = 8'h00; cyc();
      chk("t4_b_hold1", int'(b_state_q), 1);
      rule_load = 1'b0; ena = 1'b1; cyc();
      chk("t4_b_s2", int'(b_state_q), 2);
      ena = 1'b0; neighbors = 8'hFF; cyc();
      chk("t4_b_hold2", int'(b_state_q), 2);
      chk("t4_b_hold2_changed", int'(b_changed), 0);
      ena = 1'b1; cyc();
      chk("t4_b_s3", int'(b_state_q), 3);
      neighbors = 8'b0000_0111; cyc();
      chk("t4_b_s0", int'(b_state_q), 0);

      // Age saturation on a stable cell
      ena = 1'b0; rule_load = 1'b1; survive_in = 9'b000001100; cyc();
      rule_load = 1'b0; ena = 1'b1;
      for (int g = 0; g < 5; g++) begin
         cyc();
         chk("t5_b_alive", int'(b_alive), 1);
         chk("t5_b_age", int'(b_age), ae((g < 3) ? g : 3));
      end
      neighbors = 8'hFF; cyc();
      chk("t5_b_dead_age", int'(b_age), 0);
      chk("t5_b_decay", int'(b_state_q), 2);

      // Mid-run reset beats ena and rule_load
      ena = 1'b0; rule_load = 1'b1; birth_in = 9'b1_0000_0001; survive_in = 9'h000; cyc();
      rst = 1'b1; ena = 1'b1; state_0 = 1'b1; birth_in = 9'h000; survive_in = 9'h000; cyc();
      chk("t6_b_q", int'(b_state_q), 1);
      chk("t6_b_changed", int'(b_changed), 0);
      chk("t6_b_age", int'(b_age), 0);
      rst = 1'b0; rule_load = 1'b0; neighbors = 8'b0000_0011; cyc();
      chk("t6_b_default_survive", int'(b_state_q), 1);
      neighbors = 8'b0000_0111; cyc();
      chk("t6_b_age_after", int'(b_age), ae(2));

      // Mixed traffic checked by the model
      for (int k = 0; k < 400; k++) begin
         rst        = ($urandom_range(0, 59) == 0);
         state_0    = 1'($urandom_range(0, 1));
         ena        = ($urandom_range(0, 3) != 0);
         rule_load  = ($urandom_range(0, 7) == 0);
         neighbors  = 8'($urandom);
         birth_in   = 9'($urandom);
         survive_in = 9'($urandom);
         cyc();
      end
      rst = 1'b0; ena = 1'b0; rule_load = 1'b0;
      @(negedge clk);
      #1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
